// File: rtl/alu_ctrl_if.sv
// alu_ctrl_if: instruction handshake, ALU issue/return and result/status bundle.
// master = instruction source + ALU side, slave = alu_ctrl.
interface alu_ctrl_if #(
    parameter int unsigned BUS_WIDTH = 8
);
    logic                 instr_valid;
    logic                 instr_ready;
    logic [15:0]          instr;

    logic [3:0]           alu_opcode;
    logic [BUS_WIDTH-1:0] alu_a;
    logic [BUS_WIDTH-1:0] alu_b;
    logic                 alu_carry_in;

    logic [BUS_WIDTH-1:0] alu_y;
    logic                 alu_carry_out;
    logic                 alu_borrow;
    logic                 alu_zero;
    logic                 alu_parity;
    logic                 alu_invalid_op;

    logic                 res_valid;
    logic [BUS_WIDTH-1:0] res_data;
    logic [1:0]           res_dst;

    logic                 flag_carry;
    logic                 flag_zero;
    logic                 flag_parity;
    logic                 err;

    modport master (
        output instr_valid, instr,
        output alu_y, alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op,
        input  instr_ready,
        input  alu_opcode, alu_a, alu_b, alu_carry_in,
        input  res_valid, res_data, res_dst,
        input  flag_carry, flag_zero, flag_parity, err
    );

    modport slave (
        input  instr_valid, instr,
        input  alu_y, alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op,
        output instr_ready,
        output alu_opcode, alu_a, alu_b, alu_carry_in,
        output res_valid, res_data, res_dst,
        output flag_carry, flag_zero, flag_parity, err
    );
endinterface

// File: rtl/alu_ctrl.sv
// alu_ctrl: IDLE -> ISSUE -> WB controller driving an external combinational ALU,
// with a 4-entry register file and carry/zero/parity status flags.
// Optional feature: define ALU_CTRL_ERR_EN for a sticky invalid-operation flag on err;
// without it err is tied 0 and invalid operations are dropped silently.
module alu_ctrl #(
    parameter int unsigned BUS_WIDTH = 8
) (
    input logic       clk,
    input logic       reset,
    alu_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [15:0]          instr_q;
    logic [BUS_WIDTH-1:0] regs [4];
    logic [BUS_WIDTH-1:0] res_data_q;
    logic [BUS_WIDTH-1:0] wb_data;
    logic [1:0]           res_dst_q;
    logic                 res_valid_q;
    logic                 flag_c, flag_z, flag_p;

    logic [3:0] op;
    logic [1:0] rd, ra, rb;
    logic       is_ldi, accept, alu_used, do_wb, alu_wb;

    assign op       = instr_q[15:12];
    assign rd       = instr_q[11:10];
    assign ra       = instr_q[9:8];
    assign rb       = instr_q[7:6];
    assign is_ldi   = (op == 4'hF);
    assign accept   = bus.instr_valid && (state == IDLE);
    assign alu_used = (state == ISSUE) && !is_ldi;
    // LDI never consults alu_invalid_op: the ALU sees opcode 0 while bypassed.
    assign alu_wb   = alu_used && !bus.alu_invalid_op;
    assign do_wb    = alu_wb || ((state == ISSUE) && is_ldi);
    assign wb_data  = is_ldi ? BUS_WIDTH'(instr_q[7:0]) : bus.alu_y;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: one pass through ISSUE and WB per accepted instruction
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and ALU drive; ALU inputs are quiet outside ISSUE and during LDI
    always_comb begin
        bus.instr_ready  = (state == IDLE);
        bus.alu_opcode   = '0;
        bus.alu_a        = '0;
        bus.alu_b        = '0;
        bus.alu_carry_in = 1'b0;
        if (alu_used) begin
            bus.alu_opcode   = op;
            bus.alu_a        = regs[ra];
            bus.alu_b        = regs[rb];
            bus.alu_carry_in = flag_c;
        end
    end

    // Instruction capture on handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       instr_q <= '0;
        else if (accept) instr_q <= bus.instr;
    end

    // Write-back of register file, result port and status flags at ISSUE->WB
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
            res_data_q  <= '0;
            res_dst_q   <= '0;
            res_valid_q <= 1'b0;
            flag_c      <= 1'b0;
            flag_z      <= 1'b0;
            flag_p      <= 1'b0;
        end else begin
            res_valid_q <= do_wb;
            if (do_wb) begin
                regs[rd]   <= wb_data;
                res_data_q <= wb_data;
                res_dst_q  <= rd;
            end
            if (alu_wb) begin
                flag_z <= bus.alu_zero;
                flag_p <= bus.alu_parity;
                if (op == 4'd1 || op == 4'd2 || op == 4'd4)
                    flag_c <= bus.alu_carry_out;
                else if (op == 4'd3 || op == 4'd5)
                    flag_c <= bus.alu_borrow;
            end
        end
    end

    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_dst     = res_dst_q;
    assign bus.flag_carry  = flag_c;
    assign bus.flag_zero   = flag_z;
    assign bus.flag_parity = flag_p;

`ifdef ALU_CTRL_ERR_EN
    logic err_q;

    // Sticky invalid-operation indicator, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                err_q <= 1'b0;
        else if (alu_used && bus.alu_invalid_op)  err_q <= 1'b1;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: drives alu_ctrl with directed and random instruction streams, plays the
// role of the downstream ALU, and compares against an instruction-level reference model.
module tb_alu_ctrl;
    localparam int unsigned BW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_ctrl_if #(.BUS_WIDTH(BW)) bus ();
    alu_ctrl #(.BUS_WIDTH(BW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [BW-1:0] y;
        logic          co;
        logic          bo;
        logic          inv;
    } alu_res_t;

    // ALU behaviour: 1 ADD, 2 ADC, 3 SUB, 4 INC, 5 SBB, 6 AND, 7 OR, 8 XOR, others invalid
    function automatic alu_res_t alu_fn(input logic [3:0] op, input logic [BW-1:0] a,
                                        input logic [BW-1:0] b, input logic cin);
        alu_res_t r;
        int s;
        int lim;
        r = '0;
        lim = 1 << BW;
        s = 0;
        case (op)
            4'd1: begin s = int'(a) + int'(b);            r.y = BW'(s); r.co = (s >= lim); end
            4'd2: begin s = int'(a) + int'(b) + int'(cin); r.y = BW'(s); r.co = (s >= lim); end
            4'd3: begin s = int'(a) - int'(b);            r.y = BW'(s); r.bo = (s < 0); end
            4'd4: begin s = int'(a) + 1;                  r.y = BW'(s); r.co = (s >= lim); end
            4'd5: begin s = int'(a) - int'(b) - int'(cin); r.y = BW'(s); r.bo = (s < 0); end
            4'd6: r.y = a & b;
            4'd7: r.y = a | b;
            4'd8: r.y = a ^ b;
            default: r.inv = 1'b1;
        endcase
        return r;
    endfunction

    // The ALU the controller drives
    alu_res_t alu_out;
    always_comb begin
        alu_out            = alu_fn(bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_carry_in);
        bus.alu_y          = alu_out.y;
        bus.alu_carry_out  = alu_out.co;
        bus.alu_borrow     = alu_out.bo;
        bus.alu_invalid_op = alu_out.inv;
        bus.alu_zero       = (alu_out.y == '0);
        bus.alu_parity     = ^alu_out.y;
    end

    // Reference model: architectural state at instruction granularity
    logic [BW-1:0] m_regs [4];
    logic          m_c, m_z, m_p, m_err;
    logic [BW-1:0] m_res_data;
    logic [1:0]    m_res_dst;

    logic [3:0]    exp_opcode;
    logic [BW-1:0] exp_a, exp_b;
    logic          exp_cin, exp_rv;

    logic [3:0]    obs_opcode;
    logic [BW-1:0] obs_a, obs_b, obs_data;
    logic          obs_cin, obs_rv, obs_rv_after, obs_ready_after;
    logic [1:0]    obs_dst;
    logic          obs_c, obs_z, obs_p, obs_err;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_c = 0; m_z = 0; m_p = 0; m_err = 0;
        m_res_data = '0; m_res_dst = '0;
    endtask

    task automatic model_predict(input logic [15:0] ins);
        logic [3:0] op;
        logic [1:0] rd, ra, rb;
        alu_res_t r;
        op = ins[15:12]; rd = ins[11:10]; ra = ins[9:8]; rb = ins[7:6];
        if (op == 4'hF) begin
            exp_opcode = '0; exp_a = '0; exp_b = '0; exp_cin = 1'b0; exp_rv = 1'b1;
            m_regs[rd] = BW'(ins[7:0]);
            m_res_data = BW'(ins[7:0]);
            m_res_dst  = rd;
        end else begin
            exp_opcode = op; exp_a = m_regs[ra]; exp_b = m_regs[rb]; exp_cin = m_c;
            r = alu_fn(op, m_regs[ra], m_regs[rb], m_c);
            if (r.inv) begin
                exp_rv = 1'b0;
`ifdef ALU_CTRL_ERR_EN
                m_err = 1'b1;
`endif
            end else begin
                exp_rv = 1'b1;
                m_regs[rd] = r.y;
                m_res_data = r.y;
                m_res_dst  = rd;
                m_z = (r.y == '0);
                m_p = ^r.y;
                if (op == 4'd1 || op == 4'd2 || op == 4'd4) m_c = r.co;
                else if (op == 4'd3 || op == 4'd5)          m_c = r.bo;
            end
        end
    endtask

    function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
        return {4'hF, rd, 2'b00, imm};
    endfunction

    function automatic logic [15:0] aop(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] ra, input logic [1:0] rb);
        return {op, rd, ra, rb, 6'b0};
    endfunction

    // Starts and ends on a falling edge; returns 1 in to if the controller never became ready
    task automatic run_instr(input logic [15:0] ins, output logic to);
        int n;
        to = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr = 16'($urandom);
        n = 0;
        while (!bus.instr_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!bus.instr_ready) begin
            to = 1'b1;
            return;
        end
        bus.instr_valid = 1'b1;
        bus.instr = ins;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.instr = 16'($urandom);
        obs_opcode = bus.alu_opcode; obs_a = bus.alu_a; obs_b = bus.alu_b;
        obs_cin = bus.alu_carry_in;
        @(negedge clk);
        obs_rv = bus.res_valid; obs_data = bus.res_data; obs_dst = bus.res_dst;
        obs_c = bus.flag_carry; obs_z = bus.flag_zero; obs_p = bus.flag_parity;
        obs_err = bus.err;
        @(negedge clk);
        obs_rv_after = bus.res_valid;
        obs_ready_after = bus.instr_ready;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        model_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({bus.res_valid, bus.res_data, bus.res_dst, bus.flag_carry, bus.flag_zero,
             bus.flag_parity, bus.err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rv=%0b data=%0d dst=%0d c=%0b z=%0b p=%0b err=%0b, required all 0",
                     bus.res_valid, bus.res_data, bus.res_dst, bus.flag_carry, bus.flag_zero,
                     bus.flag_parity, bus.err);
        end
        n_tests++;
        if ({bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_carry_in} !== '0) begin
            n_fail++;
            $display("FAIL reset_alu: op=%0d a=%0d b=%0d cin=%0b, required 0",
                     bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_carry_in);
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %0b, required 1", bus.instr_ready);
        end
    endtask

    task automatic test_add();
        logic to;
        model_predict(ldi(2'd0, 8'd9));  run_instr(ldi(2'd0, 8'd9), to);
        model_predict(ldi(2'd1, 8'd33)); run_instr(ldi(2'd1, 8'd33), to);
        model_predict(aop(4'd1, 2'd2, 2'd0, 2'd1)); run_instr(aop(4'd1, 2'd2, 2'd0, 2'd1), to);
        n_tests++;
        if (to || obs_rv !== 1'b1 || obs_data !== 8'd42 || obs_dst !== 2'd2) begin
            n_fail++;
            $display("FAIL add_result: to=%0b rv=%0b data=%0d dst=%0d, required rv=1 data=42 dst=2",
                     to, obs_rv, obs_data, obs_dst);
        end
        n_tests++;
        if (obs_c !== 1'b0 || obs_z !== 1'b0) begin
            n_fail++;
            $display("FAIL add_flags: c=%0b z=%0b, required c=0 z=0", obs_c, obs_z);
        end
        n_tests++;
        if (obs_opcode !== 4'd1 || obs_a !== 8'd9 || obs_b !== 8'd33) begin
            n_fail++;
            $display("FAIL add_issue: op=%0d a=%0d b=%0d, required 1/9/33", obs_opcode, obs_a, obs_b);
        end
    endtask

    task automatic test_carry();
        logic to;
        model_predict(ldi(2'd0, 8'd200)); run_instr(ldi(2'd0, 8'd200), to);
        model_predict(ldi(2'd1, 8'd100)); run_instr(ldi(2'd1, 8'd100), to);
        model_predict(aop(4'd1, 2'd2, 2'd0, 2'd1)); run_instr(aop(4'd1, 2'd2, 2'd0, 2'd1), to);
        n_tests++;
        if (to || obs_data !== 8'd44 || obs_c !== 1'b1) begin
            n_fail++;
            $display("FAIL add_carry: data=%0d c=%0b, required 44/1", obs_data, obs_c);
        end
        model_predict(aop(4'd2, 2'd3, 2'd0, 2'd1)); run_instr(aop(4'd2, 2'd3, 2'd0, 2'd1), to);
        n_tests++;
        if (to || obs_cin !== 1'b1 || obs_data !== 8'd45 || obs_dst !== 2'd3) begin
            n_fail++;
            $display("FAIL adc: cin=%0b data=%0d dst=%0d, required cin=1 data=45 dst=3",
                     obs_cin, obs_data, obs_dst);
        end
    endtask

    task automatic test_sub();
        logic to;
        model_predict(ldi(2'd0, 8'd65)); run_instr(ldi(2'd0, 8'd65), to);
        model_predict(ldi(2'd1, 8'd66)); run_instr(ldi(2'd1, 8'd66), to);
        model_predict(aop(4'd3, 2'd2, 2'd0, 2'd1)); run_instr(aop(4'd3, 2'd2, 2'd0, 2'd1), to);
        n_tests++;
        if (to || obs_data !== 8'd255 || obs_c !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_borrow: data=%0d c=%0b, required 255/1", obs_data, obs_c);
        end
        model_predict(ldi(2'd1, 8'd64)); run_instr(ldi(2'd1, 8'd64), to);
        n_tests++;
        if (obs_c !== 1'b1) begin
            n_fail++;
            $display("FAIL ldi_keeps_flags: c=%0b, required 1", obs_c);
        end
        model_predict(aop(4'd3, 2'd2, 2'd0, 2'd1)); run_instr(aop(4'd3, 2'd2, 2'd0, 2'd1), to);
        n_tests++;
        if (to || obs_data !== 8'd1 || obs_c !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_no_borrow: data=%0d c=%0b, required 1/0", obs_data, obs_c);
        end
    endtask

    task automatic test_invalid();
        logic to;
        logic [BW-1:0] keep_data;
        logic keep_c, keep_z, keep_p;
        logic exp_err;
`ifdef ALU_CTRL_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        model_predict(ldi(2'd0, 8'd3)); run_instr(ldi(2'd0, 8'd3), to);
        model_predict(aop(4'd1, 2'd1, 2'd0, 2'd0)); run_instr(aop(4'd1, 2'd1, 2'd0, 2'd0), to);
        keep_data = obs_data; keep_c = obs_c; keep_z = obs_z; keep_p = obs_p;
        model_predict(aop(4'd0, 2'd1, 2'd0, 2'd0)); run_instr(aop(4'd0, 2'd1, 2'd0, 2'd0), to);
        n_tests++;
        if (to || obs_rv !== 1'b0 || obs_data !== keep_data || obs_data !== 8'd6) begin
            n_fail++;
            $display("FAIL invalid_no_wb: rv=%0b data=%0d, required rv=0 data=6", obs_rv, obs_data);
        end
        n_tests++;
        if ({obs_c, obs_z, obs_p} !== {keep_c, keep_z, keep_p}) begin
            n_fail++;
            $display("FAIL invalid_flags: czp=%03b, required %03b", {obs_c, obs_z, obs_p},
                     {keep_c, keep_z, keep_p});
        end
        n_tests++;
        if (obs_err !== exp_err) begin
            n_fail++;
            $display("FAIL invalid_err: got %0b, required %0b", obs_err, exp_err);
        end
        model_predict(aop(4'd7, 2'd2, 2'd1, 2'd0)); run_instr(aop(4'd7, 2'd2, 2'd1, 2'd0), to);
        n_tests++;
        if (obs_a !== 8'd6 || obs_err !== exp_err) begin
            n_fail++;
            $display("FAIL invalid_regs_kept: r1=%0d err=%0b, required 6/%0b", obs_a, obs_err, exp_err);
        end
    endtask

    task automatic test_reset_mid();
        logic to;
        model_predict(ldi(2'd0, 8'd5)); run_instr(ldi(2'd0, 8'd5), to);
        model_predict(ldi(2'd1, 8'd7)); run_instr(ldi(2'd1, 8'd7), to);
        bus.instr_valid = 1'b1;
        bus.instr = aop(4'd1, 2'd2, 2'd0, 2'd1);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        n_tests++;
        if (bus.alu_opcode !== 4'd1 || bus.alu_a !== 8'd5) begin
            n_fail++;
            $display("FAIL mid_issue: op=%0d a=%0d, required 1/5", bus.alu_opcode, bus.alu_a);
        end
        #1 reset = 1'b1;
        #1;
        n_tests++;
        if (bus.res_valid !== 1'b0 || bus.alu_opcode !== 4'd0 || bus.res_data !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_async: rv=%0b op=%0d data=%0d, required 0", bus.res_valid,
                     bus.alu_opcode, bus.res_data);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_tests++;
        if (bus.instr_ready !== 1'b1 || bus.flag_carry !== 1'b0 || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_release: ready=%0b c=%0b err=%0b, required 1/0/0", bus.instr_ready,
                     bus.flag_carry, bus.err);
        end
        @(negedge clk);
        n_tests++;
        if (bus.res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_no_wb: rv=%0b, required 0", bus.res_valid);
        end
        model_predict(aop(4'd7, 2'd0, 2'd0, 2'd1)); run_instr(aop(4'd7, 2'd0, 2'd0, 2'd1), to);
        n_tests++;
        if (to || obs_a !== '0 || obs_b !== '0) begin
            n_fail++;
            $display("FAIL mid_r01_zero: r0=%0d r1=%0d, required 0/0", obs_a, obs_b);
        end
        model_predict(aop(4'd7, 2'd0, 2'd2, 2'd3)); run_instr(aop(4'd7, 2'd0, 2'd2, 2'd3), to);
        n_tests++;
        if (to || obs_a !== '0 || obs_b !== '0) begin
            n_fail++;
            $display("FAIL mid_r23_zero: r2=%0d r3=%0d, required 0/0", obs_a, obs_b);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]    imm [4];
        logic [BW-1:0] exp_q [$];
        logic          rdy, rv;
        int            idx;
        for (int i = 0; i < 4; i++) begin
            imm[i] = 8'($urandom);
            model_predict(ldi(2'(i), imm[i]));
            exp_q.push_back(BW'(imm[i]));
        end
        idx = 0;
        bus.instr_valid = 1'b1;
        bus.instr = ldi(2'd0, imm[0]);
        for (int t = 0; t < 12; t++) begin
            rdy = bus.instr_ready;
            rv  = bus.res_valid;
            n_tests++;
            if (rdy !== (t % 3 == 0) || rv !== (t % 3 == 2)) begin
                n_fail++;
                $display("FAIL b2b_timing: cycle %0d ready=%0b rv=%0b, required %0b/%0b", t, rdy, rv,
                         (t % 3 == 0), (t % 3 == 2));
            end
            if (rv === 1'b1 && exp_q.size() > 0) begin
                n_tests++;
                if (bus.res_data !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL b2b_data: cycle %0d data=%0d, required %0d", t, bus.res_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            @(posedge clk);
            if (rdy && bus.instr_valid) idx++;
            @(negedge clk);
            if (idx >= 4) bus.instr_valid = 1'b0;
            else          bus.instr = ldi(2'(idx), imm[idx]);
        end
        bus.instr_valid = 1'b0;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: %0d results missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_random();
        logic to;
        logic [15:0] ins;
        for (int k = 0; k < 120; k++) begin
            if ($urandom_range(0, 9) < 3) ins = ldi(2'($urandom), 8'($urandom));
            else                          ins = 16'($urandom);
            model_predict(ins);
            run_instr(ins, to);
            n_tests++;
            if (to) begin
                n_fail++;
                $display("FAIL rnd_timeout: instr %0d 0x%04h never accepted, required ready", k, ins);
                continue;
            end
            if ({obs_opcode, obs_a, obs_b, obs_cin} !== {exp_opcode, exp_a, exp_b, exp_cin}) begin
                n_fail++;
                $display("FAIL rnd_issue: instr 0x%04h op=%0d a=%0d b=%0d cin=%0b, required %0d/%0d/%0d/%0b",
                         ins, obs_opcode, obs_a, obs_b, obs_cin, exp_opcode, exp_a, exp_b, exp_cin);
            end
            n_tests++;
            if (obs_rv !== exp_rv || obs_data !== m_res_data || obs_dst !== m_res_dst) begin
                n_fail++;
                $display("FAIL rnd_result: instr 0x%04h rv=%0b data=%0d dst=%0d, required %0b/%0d/%0d",
                         ins, obs_rv, obs_data, obs_dst, exp_rv, m_res_data, m_res_dst);
            end
            n_tests++;
            if ({obs_c, obs_z, obs_p, obs_err} !== {m_c, m_z, m_p, m_err}) begin
                n_fail++;
                $display("FAIL rnd_flags: instr 0x%04h czpe=%04b, required %04b", ins,
                         {obs_c, obs_z, obs_p, obs_err}, {m_c, m_z, m_p, m_err});
            end
            n_tests++;
            if (obs_rv_after !== 1'b0 || obs_ready_after !== 1'b1) begin
                n_fail++;
                $display("FAIL rnd_pulse: instr 0x%04h rv_after=%0b ready_after=%0b, required 0/1",
                         ins, obs_rv_after, obs_ready_after);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry();
        test_sub();
        test_invalid();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 8, datapath and register width (>= 8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port instr_valid  input  1  instruction word present.
REQ-005 SHALL have port instr_ready  output  1  controller can accept an instruction.
REQ-006 SHALL have port instr  input  16  fields: [15:12] op, [11:10] rd, [9:8] ra, [7:6] rb, [7:0] imm (LDI only).
REQ-007 SHALL have ports alu_opcode output 4, alu_a output BUS_WIDTH, alu_b output BUS_WIDTH, alu_carry_in output 1, all driving the downstream ALU.
REQ-008 SHALL have ports alu_y input BUS_WIDTH, alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op input 1 each, all returned combinationally by the ALU.
REQ-009 SHALL have port res_valid  output  1  one-cycle pulse per completed write-back.
REQ-010 SHALL have ports res_data output BUS_WIDTH (value written) and res_dst output 2 (register written).
REQ-011 SHALL have ports flag_carry, flag_zero, flag_parity  output  1 each  architectural status flags.
REQ-012 SHALL have port err  output  1  sticky invalid-operation indicator.

Function
REQ-013 SHALL hold a 4 x BUS_WIDTH register file r0..r3 and a 3-state FSM IDLE -> ISSUE -> WB -> IDLE.
REQ-014 instr_ready SHALL be 1 only in IDLE; instruction accepted and registered when instr_valid & instr_ready; FSM goes to ISSUE.
REQ-015 In ISSUE: alu_opcode = op, alu_a = r[ra], alu_b = r[rb], alu_carry_in = flag_carry; outside ISSUE all alu_* outputs SHALL be 0.
REQ-016 At the ISSUE->WB edge, if alu_invalid_op = 0: r[rd] <= alu_y, res_data <= alu_y, res_dst <= rd, flag_zero <= alu_zero, flag_parity <= alu_parity.
REQ-017 flag_carry SHALL update to alu_carry_out for op 1, 2, 4 and to alu_borrow for op 3, 5; otherwise unchanged.
REQ-018 op = 4'hF (LDI) SHALL bypass the ALU: alu_* held 0, r[rd] <= imm zero-extended, flags unchanged, res_valid still pulses.
REQ-019 If alu_invalid_op = 1 in ISSUE: no register or flag write, no res_valid; FSM still passes through WB.
REQ-020 res_valid SHALL be 1 exactly during WB; latency accept-edge to res_valid = 2 cycles; max throughput one instruction per 3 cycles.
REQ-021 Register read in ISSUE SHALL see all prior write-backs (rd of instruction N readable as ra/rb of N+1).
REQ-022 instr changes while not accepted SHALL have no effect.

Reset
REQ-023 reset SHALL immediately force IDLE, r0..r3 = 0, all flags = 0, err = 0, res_valid = 0, res_data = 0, res_dst = 0, alu_* = 0; instr_ready = 1 after release.
REQ-024 Reset during ISSUE or WB SHALL abort the instruction with no write-back.

Configuration
REQ-025 With ALU_CTRL_ERR_EN defined, err SHALL set on any invalid op (REQ-019) and stay 1 until reset.
REQ-026 Without ALU_CTRL_ERR_EN, err SHALL be tied 0 and invalid ops SHALL be dropped silently.

Verification
REQ-027 LDI r0=9, LDI r1=33, ADD(op1) r2=r0+r1 -> res_data=42, res_dst=2, flag_carry=0, flag_zero=0.
REQ-028 LDI r0=200, r1=100, ADD r2 -> 44, flag_carry=1; then ADC(op2) r3=r0+r1 -> 45 (alu_carry_in=1 in ISSUE).
REQ-029 LDI r0=65, r1=66, SUB(op3) r2=r0-r1 -> res_data=255, flag_carry=1; then r1=64, SUB -> 1, flag_carry=0.
REQ-030 op=0 (ALU flags invalid_op) -> no res_valid, registers/flags unchanged, err=1 with ALU_CTRL_ERR_EN, 0 without.
REQ-031 reset asserted mid-ISSUE of ADD -> no res_valid, r0..r3=0, instr_ready=1 first cycle after release.
REQ-032 instr_valid held 1 with 4 back-to-back LDIs -> accepts on cycles 0,3,6,9; res_valid on 2,5,8,11.
